entropy_src_markov_ht_tracker: RTL
==================================

# entropy_src_markov_ht_tracker

Downstream companion to the Markov health test in entropy_src. Samples the Markov test's per-window counts and fail pulses at every window wrap. Maintains high/low watermarks, saturating total fail counters and a consecutive-failing-window counter. Raises a one-cycle alert pulse plus a sticky alert flag when the consecutive count reaches a programmable threshold.

## Interface
- RegWidth, 16, width of Markov test counts and watermarks
- ConsecWidth, 4, width of consecutive-fail counter and alert threshold
- TotalWidth, 16, width of total fail counters
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- active_i  in  1  health test enabled; low forces Idle, all state held
- clear_i  in  1  synchronous clear of all state to reset values
- window_wrap_pulse_i  in  1  end-of-window strobe, same cycle as the Markov fail pulses
- test_cnt_hi_i  in  RegWidth  Markov high-side count, valid on wrap
- test_cnt_lo_i  in  RegWidth  Markov low-side count, valid on wrap
- test_fail_hi_pulse_i  in  1  Markov high-threshold fail
- test_fail_lo_pulse_i  in  1  Markov low-threshold fail
- count_err_i  in  1  Markov counter integrity error
- alert_thresh_i  in  ConsecWidth  consecutive failing windows to alert; 0 disables
- watermark_hi_o  out  RegWidth  max test_cnt_hi_i seen at wraps; reset 0
- watermark_lo_o  out  RegWidth  min test_cnt_lo_i seen at wraps; reset all ones
- total_fail_hi_o  out  TotalWidth  saturating count of hi fails; reset 0
- total_fail_lo_o  out  TotalWidth  saturating count of lo fails; reset 0
- consec_fail_o  out  ConsecWidth  current consecutive failing windows; reset 0
- alert_pulse_o  out  1  one-cycle alert; reset 0
- alert_latched_o  out  1  sticky alert; reset 0
- err_o  out  1  sticky integrity error; reset 0

## Operation
- FSM states: Idle, Run, Alerted. Reset -> Idle.
- Idle -> Run when active_i=1 and clear_i=0.
- Run -> Alerted when a failing wrap makes the next consec count >= alert_thresh_i, with alert_thresh_i != 0.
- Run/Alerted -> Idle when active_i=0. Clear from any state -> Idle.
- Alerted stays Alerted until clear_i or !active_i.
- A wrap is qualified when window_wrap_pulse_i=1, active_i=1, clear_i=0 and the state is Run or Alerted.
- On a qualified wrap: watermark_hi = max(watermark_hi, test_cnt_hi_i) and watermark_lo = min(watermark_lo, test_cnt_lo_i), unsigned compare.
- Each asserted fail pulse increments its total counter by 1, saturating at all ones.
- Failing window = hi or lo fail. A failing window increments consec by 1, saturating at all ones. A passing window loads consec with 0. Simultaneous hi+lo fail counts as one window.
- alert_pulse_o fires only on the Run -> Alerted transition. alert_latched_o sets on the same edge.
- err_o sets sticky on count_err_i in any state, including Idle.
- clear_i has priority over wrap and active_i. It restores every output to its reset value, including err_o and alert_latched_o.
- With !active_i, counters and watermarks hold (remain readable). FSM returns to Idle and alert_latched_o holds.

## Timing
- All outputs are registered. Wrap at cycle N -> updated outputs visible at N+1.
- alert_pulse_o is high for exactly cycle N+1, with no combinational path from the inputs.
- A wrap in the same cycle as the Idle -> Run transition is not qualified.
- Reset mid-operation: asynchronous, immediate return to reset values.

## Configuration
- ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN defined:
  - FSM state uses a Hamming-distance-3 encoding; any illegal state sets err_o and forces Alerted.
  - consec counter is duplicated (second copy inverted); any mismatch sets err_o.
- Undefined: plain binary FSM, single counter, err_o driven by count_err_i only.

## Test plan
- Three wraps with test_cnt_hi_i = 5, 9, 7 and test_cnt_lo_i = 4, 2, 3, no fails -> watermark_hi_o=9, watermark_lo_o=2, consec_fail_o=0.
- alert_thresh_i=3; fail, fail, pass, fail, fail, fail wraps -> consec goes 1,2,0,1,2,3. alert_pulse_o is high for exactly one cycle after the 6th wrap. alert_latched_o=1 and stays set on later passing wraps.
- TotalWidth=4; 17 wraps, each with a simultaneous hi and lo fail -> both totals saturate at 15. consec_fail_o saturates at 15. Only one alert pulse.
- clear_i asserted in the same cycle as a failing wrap -> next cycle all outputs equal their reset values; the wrap is ignored.
- Drop active_i for 5 cycles with wraps pulsing -> state holds. Re-assert active_i -> the first wrap is ignored only when it coincides with the Idle -> Run cycle.
- With ERR_CHK_EN: force the FSM state register to an illegal value -> err_o=1 next cycle and stays 1 until clear_i.

Source files
------------

// File: rtl/entropy_src_markov_ht_tracker_if.sv
// Signal bundle between the Markov health-test tracker and its producer/consumer.
// Sizing parameters must match those of the tracker instance.
interface entropy_src_markov_ht_tracker_if #(
    parameter int RegWidth    = 16,
    parameter int ConsecWidth = 4,
    parameter int TotalWidth  = 16
);
    logic                   active;
    logic                   clear;
    logic                   window_wrap_pulse;
    logic [RegWidth-1:0]    test_cnt_hi;
    logic [RegWidth-1:0]    test_cnt_lo;
    logic                   test_fail_hi_pulse;
    logic                   test_fail_lo_pulse;
    logic                   count_err;
    logic [ConsecWidth-1:0] alert_thresh;

    logic [RegWidth-1:0]    watermark_hi;
    logic [RegWidth-1:0]    watermark_lo;
    logic [TotalWidth-1:0]  total_fail_hi;
    logic [TotalWidth-1:0]  total_fail_lo;
    logic [ConsecWidth-1:0] consec_fail;
    logic                   alert_pulse;
    logic                   alert_latched;
    logic                   err;

    modport master (
        output active, clear, window_wrap_pulse, test_cnt_hi, test_cnt_lo,
               test_fail_hi_pulse, test_fail_lo_pulse, count_err, alert_thresh,
        input  watermark_hi, watermark_lo, total_fail_hi, total_fail_lo,
               consec_fail, alert_pulse, alert_latched, err
    );

    modport slave (
        input  active, clear, window_wrap_pulse, test_cnt_hi, test_cnt_lo,
               test_fail_hi_pulse, test_fail_lo_pulse, count_err, alert_thresh,
        output watermark_hi, watermark_lo, total_fail_hi, total_fail_lo,
               consec_fail, alert_pulse, alert_latched, err
    );
endinterface

// File: rtl/entropy_src_markov_ht_tracker.sv
// Tracks Markov health-test windows: watermarks, saturating fail totals, consecutive-fail alert.
// Define ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN for hardened FSM encoding and a shadowed consec counter.
//
// state   | meaning
// Idle    | test disabled or just cleared; wraps ignored
// Run     | tracking windows, no alert yet
// Alerted | consecutive-fail threshold reached; keeps tracking until clear/inactive
module entropy_src_markov_ht_tracker #(
    parameter int RegWidth    = 16,
    parameter int ConsecWidth = 4,
    parameter int TotalWidth  = 16
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    entropy_src_markov_ht_tracker_if.slave bus
);

`ifdef ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN
    // Pairwise Hamming distance >= 3 so a single upset never lands on another legal state.
    localparam int StateW = 5;
    typedef enum logic [StateW-1:0] {
        Idle    = 5'b00000,
        Run     = 5'b00111,
        Alerted = 5'b11001
    } state_e;
`else
    localparam int StateW = 2;
    typedef enum logic [StateW-1:0] {
        Idle    = 2'b00,
        Run     = 2'b01,
        Alerted = 2'b10
    } state_e;
`endif

    // Held as a raw vector so illegal encodings remain representable.
    logic [StateW-1:0]      state_q;
    state_e                 state_d;

    logic [RegWidth-1:0]    wm_hi_q;
    logic [RegWidth-1:0]    wm_lo_q;
    logic [TotalWidth-1:0]  tot_hi_q;
    logic [TotalWidth-1:0]  tot_lo_q;
    logic [ConsecWidth-1:0] consec_q;
    logic [ConsecWidth-1:0] consec_nxt;
    logic                   alert_pulse_q;
    logic                   alert_latched_q;
    logic                   err_q;

    logic                   tracking;
    logic                   wrap_ok;
    logic                   fail_win;
    logic                   go_alert;
    logic                   pulse_d;
    logic                   chk_err;

`ifdef ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN
    logic [ConsecWidth-1:0] consec_n_q;
    logic                   state_illegal;

    assign state_illegal = (state_q != Idle) && (state_q != Run) && (state_q != Alerted);
    assign chk_err       = state_illegal || (consec_q != ~consec_n_q);
`else
    assign chk_err       = 1'b0;
`endif

    assign tracking = (state_q == Run) || (state_q == Alerted);
    assign wrap_ok  = bus.window_wrap_pulse && bus.active && !bus.clear && tracking;
    assign fail_win = bus.test_fail_hi_pulse || bus.test_fail_lo_pulse;

    always_comb begin
        consec_nxt = '0;
        if (fail_win) begin
            consec_nxt = (&consec_q) ? consec_q : consec_q + ConsecWidth'(1);
        end
    end

    assign go_alert = wrap_ok && fail_win && (bus.alert_thresh != '0)
                      && (consec_nxt >= bus.alert_thresh);

    always_comb begin
        state_d = Idle;
        case (state_q)
            Idle:    state_d = bus.active ? Run : Idle;
            Run:     state_d = go_alert ? Alerted : Run;
            Alerted: state_d = Alerted;
            default: begin
`ifdef ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN
                state_d = Alerted;
`else
                state_d = Idle;
`endif
            end
        endcase
        if (bus.clear || !bus.active) begin
            state_d = Idle;
        end
    end

    assign pulse_d = (state_q == Run) && (state_d == Alerted);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= Idle;
            wm_hi_q         <= '0;
            wm_lo_q         <= '1;
            tot_hi_q        <= '0;
            tot_lo_q        <= '0;
            consec_q        <= '0;
            alert_pulse_q   <= 1'b0;
            alert_latched_q <= 1'b0;
            err_q           <= 1'b0;
        end else if (bus.clear) begin
            state_q         <= Idle;
            wm_hi_q         <= '0;
            wm_lo_q         <= '1;
            tot_hi_q        <= '0;
            tot_lo_q        <= '0;
            consec_q        <= '0;
            alert_pulse_q   <= 1'b0;
            alert_latched_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q       <= state_d;
            alert_pulse_q <= pulse_d;
            if (pulse_d) begin
                alert_latched_q <= 1'b1;
            end
            err_q <= err_q | bus.count_err | chk_err;
            if (wrap_ok) begin
                if (bus.test_cnt_hi > wm_hi_q) wm_hi_q <= bus.test_cnt_hi;
                if (bus.test_cnt_lo < wm_lo_q) wm_lo_q <= bus.test_cnt_lo;
                if (bus.test_fail_hi_pulse && !(&tot_hi_q)) tot_hi_q <= tot_hi_q + TotalWidth'(1);
                if (bus.test_fail_lo_pulse && !(&tot_lo_q)) tot_lo_q <= tot_lo_q + TotalWidth'(1);
                consec_q <= consec_nxt;
            end
        end
    end

`ifdef ENTROPY_SRC_MARKOV_TRACKER_ERR_CHK_EN
    // Inverted shadow copy of the consecutive counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            consec_n_q <= '1;
        end else if (bus.clear) begin
            consec_n_q <= '1;
        end else if (wrap_ok) begin
            consec_n_q <= ~consec_nxt;
        end
    end
`endif

    assign bus.watermark_hi  = wm_hi_q;
    assign bus.watermark_lo  = wm_lo_q;
    assign bus.total_fail_hi = tot_hi_q;
    assign bus.total_fail_lo = tot_lo_q;
    assign bus.consec_fail   = consec_q;
    assign bus.alert_pulse   = alert_pulse_q;
    assign bus.alert_latched = alert_latched_q;
    assign bus.err           = err_q;

endmodule
